pipeline_control: RTL
=====================

Name: pipeline_control

Overview:
Decodes the ID-stage instruction and carries the resulting control bits through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage RISC-V core. It detects load-use hazards, producing a stall and inserting a bubble, and applies branch flushes. It exports per-stage control and destination-register information for the forwarding unit and datapath muxes. Opcode, register-address and ALUOp widths are parametrised, and illegal opcodes are flagged rather than decoded as don't-care.

Parameters:
OP_W, 7, opcode width (decode uses all OP_W bits; constants below assume 7)
REG_W, 5, register address width
ALUOP_W, 2, ALUOp field width to ALU_Control

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
Op_i  input  OP_W  opcode of instruction in ID
RS1_i  input  REG_W  ID rs1 address
RS2_i  input  REG_W  ID rs2 address
RD_i  input  REG_W  ID rd address
Flush_i  input  1  branch resolved taken; squash instruction in ID
Branch_id_o  output  1  ID instruction is beq (combinational)
Stall_o  output  1  hold PC and IF/ID (combinational)
Illegal_o  output  1  ID opcode unrecognised (combinational)
ALUSrc_ex_o  output  1  EX: select immediate
ALUOp_ex_o  output  ALUOP_W  EX: ALUOp
MemRead_mem_o  output  1  MEM: load
MemWrite_mem_o  output  1  MEM: store
RegWrite_mem_o  output  1  MEM: writes rd (forwarding)
RD_mem_o  output  REG_W  MEM: rd (forwarding)
RegWrite_wb_o  output  1  WB: write enable
ResultSrc_wb_o  output  1  WB: 1 = memory data, 0 = ALU result
RD_wb_o  output  REG_W  WB: rd

Behaviour:
- Decode (combinational, full opcode match). Fields: ALUSrc/ResultSrc/RegWrite/ALUOp/MemRead/MemWrite/Branch/usesRS2.
  - 0110011 R: 0/0/1/10/0/0/0/1
  - 0010011 addi: 1/0/1/00/0/0/0/0
  - 0000011 lw: 1/1/1/00/1/0/0/0
  - 0100011 sw: 1/0/0/00/0/1/0/1
  - 1100011 beq: 0/0/0/01/0/0/1/1
  - Any other opcode: all controls 0 (NOP), Illegal_o=1.
  - No X values ever driven.
- RegWrite is forced 0 at decode when RD_i==0.
- Internal stage registers:
  - ID/EX: ALUSrc, ALUOp, MemRead, MemWrite, RegWrite, ResultSrc, RD.
  - EX/MEM: MemRead, MemWrite, RegWrite, ResultSrc, RD.
  - MEM/WB: RegWrite, ResultSrc, RD.
- Latency: an instruction decoded in ID at cycle n appears on the _ex outputs at n+1, _mem at n+2, _wb at n+3. EX/MEM and MEM/WB always advance; they are never stalled.
- Load-use hazard: hz = ID/EX.MemRead & ID/EX.RD!=0 & (ID/EX.RD==RS1_i | (usesRS2 & ID/EX.RD==RS2_i)).
- Stall_o = hz & ~Flush_i.
- ID/EX next state:
  - Flush_i=1 → bubble (all zero). Flush has priority over stall.
  - else hz=1 → bubble (all zero); the ID instruction stays in IF/ID and is re-decoded next cycle.
  - else → decoded ID controls.
- Illegal_o and Branch_id_o reflect the raw Op_i and are not masked by stall or flush.
- Reset (rst_i=0, asynchronous, any cycle including mid-stall): all stage registers clear to 0, so every _ex/_mem/_wb output is 0 while reset is asserted. Combinational outputs follow inputs (Stall_o=0 because ID/EX.MemRead=0). The first decoded instruction reaches EX on the first rising edge after rst_i deasserts.
- A single load-use hazard produces exactly one stall cycle. Back-to-back loads each stall independently.

Test Plan:
- Reset mid-stream: assert rst_i=0 with lw in ID/EX → all registered outputs 0 immediately, Stall_o=0.
- Pipeline flow: R-type (RD=3), then addi, lw, sw, beq back-to-back → each instruction's _ex/_mem/_wb values match the decode table at n+1/n+2/n+3; RD_wb_o=3 at cycle 3.
- Load-use: lw x5, then add x6,x5,x7 → Stall_o=1 for exactly 1 cycle; bubble in EX (ALUOp_ex_o=0, RegWrite 0); add reaches EX one cycle later.
- rs2 sensitivity: lw x5 then addi with RS2_i=5 → no stall. lw x5 then sw with RS2_i=5 → stall. lw x0 then add x6,x0,x0 → no stall.
- Flush priority: hazard present and Flush_i=1 in same cycle → Stall_o=0, bubble in ID/EX.
- Illegal/x0: Op_i=1111111 → Illegal_o=1 and all-zero controls propagate. R-type with RD_i=0 → RegWrite_wb_o=0 at n+3.

Source files
------------

// File: rtl/pipeline_control.sv
// ID-stage decode plus the ID/EX, EX/MEM and MEM/WB control registers of the 5-stage core.
// Detects load-use hazards (stall + bubble) and squashes the ID instruction on a taken branch.
module pipeline_control #(
  parameter int OP_W    = 7,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    Op_i,
  input  logic [REG_W-1:0]   RS1_i,
  input  logic [REG_W-1:0]   RS2_i,
  input  logic [REG_W-1:0]   RD_i,
  input  logic               Flush_i,
  output logic               Branch_id_o,
  output logic               Stall_o,
  output logic               Illegal_o,
  output logic               ALUSrc_ex_o,
  output logic [ALUOP_W-1:0] ALUOp_ex_o,
  output logic               MemRead_mem_o,
  output logic               MemWrite_mem_o,
  output logic               RegWrite_mem_o,
  output logic [REG_W-1:0]   RD_mem_o,
  output logic               RegWrite_wb_o,
  output logic               ResultSrc_wb_o,
  output logic [REG_W-1:0]   RD_wb_o
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(7'b0110011);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(7'b0010011);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(7'b0000011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(7'b0100011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(7'b1100011);

  localparam logic [ALUOP_W-1:0] ALUOP_ADD = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALUOP_SUB = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALUOP_FN  = ALUOP_W'(2'b10);

  // Decoded ID controls
  logic               dec_alusrc;
  logic               dec_resultsrc;
  logic               dec_regwrite;
  logic [ALUOP_W-1:0] dec_aluop;
  logic               dec_memread;
  logic               dec_memwrite;
  logic               dec_branch;
  logic               dec_uses_rs2;
  logic               dec_illegal;
  logic               id_regwrite;

  // ID/EX
  logic               ex_alusrc_q,    ex_alusrc_d;
  logic [ALUOP_W-1:0] ex_aluop_q,     ex_aluop_d;
  logic               ex_memread_q,   ex_memread_d;
  logic               ex_memwrite_q,  ex_memwrite_d;
  logic               ex_regwrite_q,  ex_regwrite_d;
  logic               ex_resultsrc_q, ex_resultsrc_d;
  logic [REG_W-1:0]   ex_rd_q,        ex_rd_d;

  // EX/MEM
  logic               mem_memread_q,   mem_memread_d;
  logic               mem_memwrite_q,  mem_memwrite_d;
  logic               mem_regwrite_q,  mem_regwrite_d;
  logic               mem_resultsrc_q, mem_resultsrc_d;
  logic [REG_W-1:0]   mem_rd_q,        mem_rd_d;

  // MEM/WB
  logic               wb_regwrite_q,  wb_regwrite_d;
  logic               wb_resultsrc_q, wb_resultsrc_d;
  logic [REG_W-1:0]   wb_rd_q,        wb_rd_d;

  logic hazard;
  logic bubble;

  always_comb begin
    dec_alusrc    = 1'b0;
    dec_resultsrc = 1'b0;
    dec_regwrite  = 1'b0;
    dec_aluop     = '0;
    dec_memread   = 1'b0;
    dec_memwrite  = 1'b0;
    dec_branch    = 1'b0;
    dec_uses_rs2  = 1'b0;
    dec_illegal   = 1'b0;
    case (Op_i)
      OP_RTYPE: begin
        dec_regwrite = 1'b1;
        dec_aluop    = ALUOP_FN;
        dec_uses_rs2 = 1'b1;
      end
      OP_ADDI: begin
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
        dec_aluop    = ALUOP_ADD;
      end
      OP_LW: begin
        dec_alusrc    = 1'b1;
        dec_resultsrc = 1'b1;
        dec_regwrite  = 1'b1;
        dec_aluop     = ALUOP_ADD;
        dec_memread   = 1'b1;
      end
      OP_SW: begin
        dec_alusrc   = 1'b1;
        dec_aluop    = ALUOP_ADD;
        dec_memwrite = 1'b1;
        dec_uses_rs2 = 1'b1;
      end
      OP_BEQ: begin
        dec_aluop    = ALUOP_SUB;
        dec_branch   = 1'b1;
        dec_uses_rs2 = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // x0 is never written, so a write to it is killed here rather than in WB
  assign id_regwrite = dec_regwrite & (RD_i != '0);

  assign hazard = ex_memread_q & (ex_rd_q != '0) &
                  ((ex_rd_q == RS1_i) | (dec_uses_rs2 & (ex_rd_q == RS2_i)));

  assign Stall_o     = hazard & ~Flush_i;
  assign bubble      = Flush_i | hazard;
  assign Branch_id_o = dec_branch;
  assign Illegal_o   = dec_illegal;

  always_comb begin
    ex_alusrc_d    = 1'b0;
    ex_aluop_d     = '0;
    ex_memread_d   = 1'b0;
    ex_memwrite_d  = 1'b0;
    ex_regwrite_d  = 1'b0;
    ex_resultsrc_d = 1'b0;
    ex_rd_d        = '0;
    if (!bubble) begin
      ex_alusrc_d    = dec_alusrc;
      ex_aluop_d     = dec_aluop;
      ex_memread_d   = dec_memread;
      ex_memwrite_d  = dec_memwrite;
      ex_regwrite_d  = id_regwrite;
      ex_resultsrc_d = dec_resultsrc;
      ex_rd_d        = RD_i;
    end
  end

  // Later stages always advance; only ID/EX sees bubbles
  always_comb begin
    mem_memread_d   = ex_memread_q;
    mem_memwrite_d  = ex_memwrite_q;
    mem_regwrite_d  = ex_regwrite_q;
    mem_resultsrc_d = ex_resultsrc_q;
    mem_rd_d        = ex_rd_q;
    wb_regwrite_d   = mem_regwrite_q;
    wb_resultsrc_d  = mem_resultsrc_q;
    wb_rd_d         = mem_rd_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_alusrc_q     <= 1'b0;
      ex_aluop_q      <= '0;
      ex_memread_q    <= 1'b0;
      ex_memwrite_q   <= 1'b0;
      ex_regwrite_q   <= 1'b0;
      ex_resultsrc_q  <= 1'b0;
      ex_rd_q         <= '0;
      mem_memread_q   <= 1'b0;
      mem_memwrite_q  <= 1'b0;
      mem_regwrite_q  <= 1'b0;
      mem_resultsrc_q <= 1'b0;
      mem_rd_q        <= '0;
      wb_regwrite_q   <= 1'b0;
      wb_resultsrc_q  <= 1'b0;
      wb_rd_q         <= '0;
    end else begin
      ex_alusrc_q     <= ex_alusrc_d;
      ex_aluop_q      <= ex_aluop_d;
      ex_memread_q    <= ex_memread_d;
      ex_memwrite_q   <= ex_memwrite_d;
      ex_regwrite_q   <= ex_regwrite_d;
      ex_resultsrc_q  <= ex_resultsrc_d;
      ex_rd_q         <= ex_rd_d;
      mem_memread_q   <= mem_memread_d;
      mem_memwrite_q  <= mem_memwrite_d;
      mem_regwrite_q  <= mem_regwrite_d;
      mem_resultsrc_q <= mem_resultsrc_d;
      mem_rd_q        <= mem_rd_d;
      wb_regwrite_q   <= wb_regwrite_d;
      wb_resultsrc_q  <= wb_resultsrc_d;
      wb_rd_q         <= wb_rd_d;
    end
  end

  assign ALUSrc_ex_o    = ex_alusrc_q;
  assign ALUOp_ex_o     = ex_aluop_q;
  assign MemRead_mem_o  = mem_memread_q;
  assign MemWrite_mem_o = mem_memwrite_q;
  assign RegWrite_mem_o = mem_regwrite_q;
  assign RD_mem_o       = mem_rd_q;
  assign RegWrite_wb_o  = wb_regwrite_q;
  assign ResultSrc_wb_o = wb_resultsrc_q;
  assign RD_wb_o        = wb_rd_q;

endmodule
